// File: rtl/fos_inv_seq.sv
// Sequential inverse of the first-order section filter: x[n] = x[n-1] + y[n] - ((a1*y[n-1]) >>> FRAC).
// Define FOS_INV_FASTMUL_EN to replace the iterative radix-4 Booth engine with a single-cycle multiply.
module fos_inv_seq #(
  parameter int DATA_W = 32,
  parameter int COEF_W = 11,
  parameter int FRAC   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [COEF_W-1:0] a1,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              busy
);

  // state | meaning
  // IDLE  | waiting for a sample, s_ready high
  // MUL   | forming a1*y_prev (Booth steps, or one fast multiply)
  // ACC   | reconstruct x and update history
  // OUT   | present m_data until m_ready
  typedef enum logic [1:0] {IDLE, MUL, ACC, OUT} state_t;

  localparam int PROD_W = DATA_W + COEF_W;

  state_t            state;
  logic [DATA_W-1:0] y_cur;
  logic [DATA_W-1:0] y_prev;
  logic [DATA_W-1:0] x_prev;
  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] prod_sh;
  logic [DATA_W-1:0] fb;
  logic [DATA_W-1:0] x_new;
  logic [PROD_W-DATA_W-1:0] unused_prod_hi;

  assign prod_sh        = $signed(prod) >>> FRAC;
  assign fb             = prod_sh[DATA_W-1:0];
  assign unused_prod_hi = prod_sh[PROD_W-1:DATA_W];
  assign x_new          = x_prev + y_cur - fb;

`ifdef FOS_INV_FASTMUL_EN
  logic [COEF_W-1:0]        coef;
  logic signed [PROD_W-1:0] mul_a;
  logic signed [PROD_W-1:0] mul_b;

  assign mul_a = PROD_W'($signed(y_prev));
  assign mul_b = PROD_W'($signed(coef));
`else
  localparam int STEPS  = (COEF_W + 1) / 2;
  localparam int MULT_W = 2 * STEPS;
  localparam int CNT_W  = $clog2(STEPS + 1);

  // mult_sh[0] is the implicit Booth bit below the current digit
  logic [PROD_W-1:0] mcand_sh;
  logic [MULT_W:0]   mult_sh;
  logic [CNT_W-1:0]  step_cnt;
  logic [PROD_W-1:0] pp;

  always_comb begin
    pp = '0;
    case (mult_sh[2:0])
      3'b001, 3'b010: pp = mcand_sh;
      3'b011:         pp = mcand_sh << 1;
      3'b100:         pp = -(mcand_sh << 1);
      3'b101, 3'b110: pp = -mcand_sh;
      default:        pp = '0;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      s_ready  <= 1'b0;
      busy     <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      x_prev   <= '0;
      y_prev   <= '0;
      y_cur    <= '0;
      prod     <= '0;
`ifdef FOS_INV_FASTMUL_EN
      coef     <= '0;
`else
      mcand_sh <= '0;
      mult_sh  <= '0;
      step_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          s_ready <= 1'b1;
          if (s_valid && s_ready) begin
            y_cur    <= s_data;
            prod     <= '0;
`ifdef FOS_INV_FASTMUL_EN
            coef     <= a1;
`else
            mcand_sh <= PROD_W'($signed(y_prev));
            mult_sh  <= {MULT_W'($signed(a1)), 1'b0};
            step_cnt <= CNT_W'(STEPS - 1);
`endif
            s_ready  <= 1'b0;
            busy     <= 1'b1;
            state    <= MUL;
          end
        end
        MUL: begin
`ifdef FOS_INV_FASTMUL_EN
          prod  <= mul_a * mul_b;
          state <= ACC;
`else
          prod     <= prod + pp;
          mcand_sh <= mcand_sh << 2;
          mult_sh  <= {{2{mult_sh[MULT_W]}}, mult_sh[MULT_W:2]};
          if (step_cnt == '0) state <= ACC;
          else                step_cnt <= step_cnt - 1'b1;
`endif
        end
        ACC: begin
          m_data  <= x_new;
          x_prev  <= x_new;
          y_prev  <= y_cur;
          m_valid <= 1'b1;
          state   <= OUT;
        end
        OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            busy    <= 1'b0;
            s_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fos_inv_seq.sv
// Directed self-checking bench for fos_inv_seq with hand-computed expected samples.
module tb_fos_inv_seq;

`ifdef FOS_INV_FASTMUL_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 7;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic [10:0] a1 = '0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [31:0] m_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  fos_inv_seq dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .a1(a1),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // returns after the accept edge (E0 + 1)
  task automatic send(input logic [31:0] y, input logic [10:0] c);
    int n = 0;
    s_data = y;
    a1 = c;
    s_valid = 1'b1;
    while (!s_ready && n < 50) begin
      tick();
      n++;
    end
    check("send_timeout", 32'(n < 50), 32'd1);
    tick();
    s_valid = 1'b0;
  endtask

  // waits for m_valid, checks data, then completes the handshake edge (m_ready high)
  task automatic recv(input string tag, input logic [31:0] exp);
    int n = 0;
    while (!m_valid && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, 32'(n < 50), 32'd1);
    check(tag, m_data, exp);
    tick();
  endtask

  initial begin
    int n;
    int seen;

    // reset state while reset is held
    tick();
    tick();
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_m_data", m_data, 32'd0);
    reset = 1'b0;
    tick();
    check("post_rst_s_ready", 32'(s_ready), 32'd1);

    // step reconstruction, a1 = 0.5
    send(32'd100, 11'h200); recv("step0", 32'd100);
    send(32'd50,  11'h200); recv("step1", 32'd100);
    send(32'd25,  11'h200); recv("step2", 32'd100);
    send(32'd12,  11'h200); recv("step3", 32'd100);

    // negative product truncates toward -inf
    do_reset();
    send(32'd3, 11'h7FF); recv("trunc0", 32'd3);
    send(32'd0, 11'h7FF); recv("trunc1", 32'd4);

    // negative multiplicand and coefficient: fb = 600000>>>10 = 585
    do_reset();
    send(-32'sd2000, 11'h6D4); recv("neg0", -32'sd2000);
    send(32'd0,      11'h6D4); recv("neg1", -32'sd2585);

    // wrap-around
    do_reset();
    send(32'h7FFFFFFF, 11'h000); recv("wrap0", 32'h7FFFFFFF);
    send(32'h00000001, 11'h000); recv("wrap1", 32'h80000000);

    // latency and backpressure
    do_reset();
    m_ready = 1'b0;
    send(32'd40, 11'h000);
    n = 0;
    while (!m_valid && n < 50) begin
      tick();
      n++;
    end
    check("latency", 32'(n), 32'(LAT));
    s_data = 32'd999;
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_m_data", m_data, 32'd40);
      check("bp_s_ready", 32'(s_ready), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
      tick();
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    tick();
    check("hs_m_valid", 32'(m_valid), 32'd0);
    check("hs_s_ready", 32'(s_ready), 32'd1);
    send(32'd60, 11'h000); recv("bp_next", 32'd100);

    // reset mid-MUL discards the sample and clears history
    do_reset();
    send(32'd500, 11'h3FF);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("midrst_m_valid", 32'(m_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_s_ready", 32'(s_ready), 32'd0);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (m_valid) seen = 1;
      tick();
    end
    check("midrst_no_output", 32'(seen), 32'd0);
    send(32'd7, 11'h200); recv("midrst_after", 32'd7);

    // per-sample coefficient capture, including -1.0
    do_reset();
    send(32'd1024, 11'h100); recv("coef0", 32'd1024);
    send(32'd0,    11'h400); recv("coef1", 32'd2048);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
